// File: rtl/expand_key_ctrl.sv
// expand_key_ctrl
//
// Sequencer for the Blowfish key schedule (bcrypt ExpandKey / EksBlowfish
// inner step).
//
// It first XORs the 18-word P-array with the key. It then runs the shared
// encipher engine 521 times, chaining the 64-bit block from one run to the
// next. Each result pair is written back over P[0..17] and then over the
// four S-boxes (1024 words). While busy, this block owns the P/S write ports.
//
// Ports
//   clk, reset_l              clock (rising edge), async active-low reset
//   start, salt_en, salt      start request, salt mode (latched on start),
//                             128-bit salt (W0 = [127:96] .. W3 = [31:0])
//   key_addr / key_data       key word read (combinational)
//   p_raddr / p_rdata         P read (combinational), used during KEYXOR
//   p_we, p_waddr, p_wdata    P write port
//   s_we, s_waddr, s_wdata    S write port (box = [9:8], entry = [7:0])
//   enc_start, enc_xl, enc_xr block handed to encipher, held until enc_done
//   enc_done, enc_xl_out/xr   encipher completion and result
//   busy, done                activity flag, one-cycle completion pulse
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for start
// S_KEYXOR    | P[i] <= P[i] ^ key[i], i = 0..17, one word per cycle
// S_ENC_START | present (L,R) ^ salt words to encipher, pulse enc_start
// S_ENC_WAIT  | hold block, capture result on enc_done
// S_WR_L      | write L to word 2*blk of P or S
// S_WR_R      | write R to word 2*blk+1, then next block or finish
// S_DONE      | one-cycle done pulse

module expand_key_ctrl (
    input  logic         clk,
    input  logic         reset_l,
    input  logic         start,
    input  logic         salt_en,
    input  logic [127:0] salt,
    output logic [4:0]   key_addr,
    input  logic [31:0]  key_data,
    output logic [4:0]   p_raddr,
    input  logic [31:0]  p_rdata,
    output logic         p_we,
    output logic [4:0]   p_waddr,
    output logic [31:0]  p_wdata,
    output logic         s_we,
    output logic [9:0]   s_waddr,
    output logic [31:0]  s_wdata,
    output logic         enc_start,
    output logic [31:0]  enc_xl,
    output logic [31:0]  enc_xr,
    input  logic         enc_done,
    input  logic [31:0]  enc_xl_out,
    input  logic [31:0]  enc_xr_out,
    output logic         busy,
    output logic         done
);

    localparam logic [4:0] LAST_KEY_WORD = 5'd17;
    localparam logic [9:0] LAST_BLOCK    = 10'd520;
    localparam logic [9:0] FIRST_S_BLOCK = 10'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEYXOR,
        S_ENC_START,
        S_ENC_WAIT,
        S_WR_L,
        S_WR_R,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [4:0]  r_i;
    logic [9:0]  r_blk;
    logic [31:0] r_l;
    logic [31:0] r_r;
    logic [31:0] r_enc_xl;
    logic [31:0] r_enc_xr;
    logic        r_salt_en;

    logic [31:0] w_salt_a;
    logic [31:0] w_salt_b;
    logic [31:0] w_blk_xl;
    logic [31:0] w_blk_xr;
    logic        w_to_p;
    logic [9:0]  w_s_base;
    logic [9:0]  w_s_addr_l;
    logic [4:0]  w_p_addr_l;

    // Even blocks mix in W0/W1, odd blocks W2/W3.
    assign w_salt_a = r_blk[0] ? salt[63:32] : salt[127:96];
    assign w_salt_b = r_blk[0] ? salt[31:0]  : salt[95:64];
    assign w_blk_xl = r_l ^ (r_salt_en ? w_salt_a : 32'h0);
    assign w_blk_xr = r_r ^ (r_salt_en ? w_salt_b : 32'h0);

    // Blocks 0..8 land in P, 9..520 in S. The S base underflows for P
    // blocks, but it is only used when w_to_p is low.
    assign w_to_p     = (r_blk < FIRST_S_BLOCK);
    assign w_s_base   = r_blk - FIRST_S_BLOCK;
    assign w_s_addr_l = w_s_base << 1;
    assign w_p_addr_l = {r_blk[3:0], 1'b0};

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state   <= S_IDLE;
            r_i       <= 5'd0;
            r_blk     <= 10'd0;
            r_l       <= 32'h0;
            r_r       <= 32'h0;
            r_enc_xl  <= 32'h0;
            r_enc_xr  <= 32'h0;
            r_salt_en <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_i       <= 5'd0;
                        r_blk     <= 10'd0;
                        r_l       <= 32'h0;
                        r_r       <= 32'h0;
                        r_salt_en <= salt_en;
                    end
                end
                S_KEYXOR: begin
                    if (r_i != LAST_KEY_WORD) begin
                        r_i <= r_i + 5'd1;
                    end
                end
                S_ENC_START: begin
                    r_enc_xl <= w_blk_xl;
                    r_enc_xr <= w_blk_xr;
                end
                S_ENC_WAIT: begin
                    if (enc_done) begin
                        r_l <= enc_xl_out;
                        r_r <= enc_xr_out;
                    end
                end
                S_WR_R: begin
                    if (r_blk != LAST_BLOCK) begin
                        r_blk <= r_blk + 10'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        key_addr     = 5'd0;
        p_raddr      = 5'd0;
        p_we         = 1'b0;
        p_waddr      = 5'd0;
        p_wdata      = 32'h0;
        s_we         = 1'b0;
        s_waddr      = 10'd0;
        s_wdata      = 32'h0;
        enc_start    = 1'b0;
        enc_xl       = 32'h0;
        enc_xr       = 32'h0;
        busy         = (r_state != S_IDLE);
        done         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_KEYXOR;
                end
            end
            S_KEYXOR: begin
                key_addr = r_i;
                p_raddr  = r_i;
                p_we     = 1'b1;
                p_waddr  = r_i;
                p_wdata  = p_rdata ^ key_data;
                if (r_i == LAST_KEY_WORD) begin
                    w_next_state = S_ENC_START;
                end
            end
            S_ENC_START: begin
                enc_start    = 1'b1;
                enc_xl       = w_blk_xl;
                enc_xr       = w_blk_xr;
                w_next_state = S_ENC_WAIT;
            end
            S_ENC_WAIT: begin
                // The registered copy keeps the block stable for the engine.
                enc_xl = r_enc_xl;
                enc_xr = r_enc_xr;
                if (enc_done) begin
                    w_next_state = S_WR_L;
                end
            end
            S_WR_L: begin
                if (w_to_p) begin
                    p_we    = 1'b1;
                    p_waddr = w_p_addr_l;
                    p_wdata = r_l;
                end else begin
                    s_we    = 1'b1;
                    s_waddr = w_s_addr_l;
                    s_wdata = r_l;
                end
                w_next_state = S_WR_R;
            end
            S_WR_R: begin
                if (w_to_p) begin
                    p_we    = 1'b1;
                    p_waddr = w_p_addr_l | 5'd1;
                    p_wdata = r_r;
                end else begin
                    s_we    = 1'b1;
                    s_waddr = w_s_addr_l | 10'd1;
                    s_wdata = r_r;
                end
                if (r_blk == LAST_BLOCK) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_ENC_START;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_expand_key_ctrl.sv
// Testbench for expand_key_ctrl.
//
// The bench models the P/S/key memories and a stub encipher engine. The stub
// returns xl_out = xr + 1 and xr_out = xl ^ A5A5A5A5, with a per-block
// latency W. A plain software model of the key schedule produces the
// expected enc_start blocks, the ordered write stream, the final memory
// contents and the done latency. All per-cycle checking is done in tick(),
// which samples the DUT on the falling edge.
module tb_expand_key_ctrl;

    logic         clk;
    logic         reset_l;
    logic         start;
    logic         salt_en;
    logic [127:0] salt;
    logic [4:0]   key_addr;
    logic [31:0]  key_data;
    logic [4:0]   p_raddr;
    logic [31:0]  p_rdata;
    logic         p_we;
    logic [4:0]   p_waddr;
    logic [31:0]  p_wdata;
    logic         s_we;
    logic [9:0]   s_waddr;
    logic [31:0]  s_wdata;
    logic         enc_start;
    logic [31:0]  enc_xl;
    logic [31:0]  enc_xr;
    logic         enc_done;
    logic [31:0]  enc_xl_out;
    logic [31:0]  enc_xr_out;
    logic         busy;
    logic         done;

    expand_key_ctrl dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .start      (start),
        .salt_en    (salt_en),
        .salt       (salt),
        .key_addr   (key_addr),
        .key_data   (key_data),
        .p_raddr    (p_raddr),
        .p_rdata    (p_rdata),
        .p_we       (p_we),
        .p_waddr    (p_waddr),
        .p_wdata    (p_wdata),
        .s_we       (s_we),
        .s_waddr    (s_waddr),
        .s_wdata    (s_wdata),
        .enc_start  (enc_start),
        .enc_xl     (enc_xl),
        .enc_xr     (enc_xr),
        .enc_done   (enc_done),
        .enc_xl_out (enc_xl_out),
        .enc_xr_out (enc_xr_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] p_mem   [18];
    logic [31:0] s_mem   [1024];
    logic [31:0] key_mem [18];

    assign p_rdata  = (p_raddr  < 5'd18) ? p_mem[p_raddr]    : 32'h0;
    assign key_data = (key_addr < 5'd18) ? key_mem[key_addr] : 32'h0;

    int          checks;
    int          failures;
    int          cyc;
    int          stub_cnt;
    logic [31:0] stub_xl;
    logic [31:0] stub_xr;
    int          enc_seen;
    int          done_seen;
    bit          spur;
    int          w_tab [521];
    logic [63:0] enc_log [3];
    logic [42:0] wr_q [$];
    logic [63:0] enc_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, "_ctl"}, 64'({key_addr, p_raddr, p_waddr, s_waddr, p_we, s_we, enc_start, busy, done}), 64'h0);
        chk({name, "_wdata"}, {p_wdata, s_wdata}, 64'h0);
        chk({name, "_enc"}, {enc_xl, enc_xr}, 64'h0);
    endtask

    // One clock cycle: sample on the falling edge, check, commit memory
    // writes, then drive the stub engine for the rest of the cycle.
    task automatic tick();
        logic [63:0] e;
        logic [42:0] got;
        @(negedge clk);
        cyc++;
        if (!reset_l) begin
            stub_cnt = 0;
            enc_done = 1'b0;
            return;
        end
        if (stub_cnt > 0) begin
            chk("no_activity_before_enc_done", 64'({p_we, s_we, enc_start}), 64'h0);
            chk("enc_block_held", {enc_xl, enc_xr}, {stub_xl, stub_xr});
        end
        if (p_we || s_we) begin
            chk("p_s_we_exclusive", 64'(p_we & s_we), 64'h0);
            got = s_we ? {1'b1, s_waddr, s_wdata} : {1'b0, 5'd0, p_waddr, p_wdata};
            chk("write_expected", 64'(wr_q.size() != 0), 64'h1);
            if (wr_q.size() != 0) begin
                e = 64'(wr_q.pop_front());
                chk("write_seq", 64'(got), e);
            end
            if (s_we) s_mem[s_waddr] = s_wdata;
            else if (p_waddr < 5'd18) p_mem[p_waddr] = p_wdata;
        end
        if (enc_start) begin
            if (enc_seen < 3) enc_log[enc_seen] = {enc_xl, enc_xr};
            chk("enc_start_expected", 64'(enc_q.size() != 0), 64'h1);
            if (enc_q.size() != 0) begin
                e = enc_q.pop_front();
                chk("enc_block", {enc_xl, enc_xr}, e);
            end
            stub_xl  = enc_xl;
            stub_xr  = enc_xr;
            stub_cnt = (enc_seen < 521) ? w_tab[enc_seen] : 3;
            enc_seen++;
            enc_done = 1'b0;
        end else if (stub_cnt > 0) begin
            stub_cnt--;
            enc_done = (stub_cnt == 0);
            if (enc_done) begin
                enc_xl_out = stub_xr + 32'd1;
                enc_xr_out = stub_xl ^ 32'hA5A5_A5A5;
            end else begin
                enc_xl_out = $urandom;
                enc_xr_out = $urandom;
            end
        end else begin
            enc_done   = spur;
            enc_xl_out = $urandom;
            enc_xr_out = $urandom;
        end
        if (done) done_seen++;
    endtask

    task automatic run(input bit se, input logic [127:0] sl, input bit rand_w,
                       input bit extra_start, input bit spur_kx, input int abort_blk,
                       input bit pin_plain);
        logic [31:0] mp [18];
        logic [31:0] ms [1024];
        logic [31:0] l, r, xl, xr;
        int          tot;
        int          n;
        int          mism;

        // Reference: key XOR, then 521 chained stub encipherments.
        wr_q.delete();
        enc_q.delete();
        for (int k = 0; k < 18; k++) begin
            mp[k] = p_mem[k] ^ key_mem[k];
            wr_q.push_back({1'b0, 5'd0, 5'(k), mp[k]});
        end
        for (int k = 0; k < 1024; k++) ms[k] = s_mem[k];
        l   = 32'h0;
        r   = 32'h0;
        tot = 19;
        for (int b = 0; b < 521; b++) begin
            w_tab[b] = rand_w ? int'($urandom_range(1, 10)) : 3;
            tot += 3 + w_tab[b];
            xl = l ^ (se ? ((b % 2) != 0 ? sl[63:32] : sl[127:96]) : 32'h0);
            xr = r ^ (se ? ((b % 2) != 0 ? sl[31:0]  : sl[95:64])  : 32'h0);
            enc_q.push_back({xl, xr});
            l = xr + 32'd1;
            r = xl ^ 32'hA5A5_A5A5;
            if (b < 9) begin
                mp[2*b]   = l;
                mp[2*b+1] = r;
                wr_q.push_back({1'b0, 5'd0, 5'(2*b),   l});
                wr_q.push_back({1'b0, 5'd0, 5'(2*b+1), r});
            end else begin
                ms[2*(b-9)]   = l;
                ms[2*(b-9)+1] = r;
                wr_q.push_back({1'b1, 10'(2*(b-9)),   l});
                wr_q.push_back({1'b1, 10'(2*(b-9)+1), r});
            end
        end

        enc_seen  = 0;
        done_seen = 0;
        n         = 0;
        salt_en   = se;
        salt      = sl;
        start     = 1'b1;
        do begin
            tick();
            n++;
            start   = extra_start && (n == 5 || n == 500);
            spur    = spur_kx && (n >= 2) && (n <= 15);
            salt_en = ~se;
            if (n == 1) chk("busy_after_start", 64'(busy), 64'h1);
            if (pin_plain && n == 19) begin
                for (int k = 0; k < 18; k++)
                    chk("keyxor_p", 64'(p_mem[k]), 64'(32'(k) ^ (32'(k) << 8)));
            end
            if (pin_plain && n == 25) begin
                chk("blk0_p0", 64'(p_mem[0]), 64'h1);
                chk("blk0_p1", 64'(p_mem[1]), 64'hA5A5_A5A5);
            end
            if (abort_blk >= 0 && enc_seen == abort_blk + 1 && stub_cnt == 2) begin
                reset_l = 1'b0;
                #1;
                check_zero("mid_reset");
                repeat (4) begin
                    tick();
                    chk("no_done_in_reset", 64'(done), 64'h0);
                end
                reset_l = 1'b1;
                start   = 1'b0;
                spur    = 1'b0;
                wr_q.delete();
                enc_q.delete();
                repeat (5) begin
                    tick();
                    chk("idle_after_reset", 64'({busy, done}), 64'h0);
                end
                chk("no_done_after_abort", 64'(done_seen), 64'h0);
                return;
            end
        end while (done_seen == 0 && n < tot + 100);

        start = 1'b0;
        spur  = 1'b0;
        chk("done_count", 64'(done_seen), 64'd1);
        chk("done_latency", 64'(n), 64'(tot));
        chk("busy_in_done", 64'(busy), 64'h1);
        tick();
        chk("busy_after_done", 64'(busy), 64'h0);
        repeat (8) tick();
        chk("single_done", 64'(done_seen), 64'd1);
        chk("queues_drained", 64'(wr_q.size() + enc_q.size()), 64'h0);
        mism = 0;
        for (int k = 0; k < 18; k++)   if (p_mem[k] !== mp[k]) mism++;
        for (int k = 0; k < 1024; k++) if (s_mem[k] !== ms[k]) mism++;
        chk("final_memory_mismatches", 64'(mism), 64'h0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        cyc        = 0;
        stub_cnt   = 0;
        stub_xl    = 32'h0;
        stub_xr    = 32'h0;
        enc_seen   = 0;
        done_seen  = 0;
        spur       = 1'b0;
        reset_l    = 1'b0;
        start      = 1'b0;
        salt_en    = 1'b0;
        salt       = 128'h0;
        enc_done   = 1'b0;
        enc_xl_out = 32'h0;
        enc_xr_out = 32'h0;
        for (int k = 0; k < 18; k++) begin
            p_mem[k]   = 32'(k);
            key_mem[k] = 32'h100 * 32'(k);
        end
        for (int k = 0; k < 1024; k++) s_mem[k] = 32'h0;
        for (int k = 0; k < 3; k++) enc_log[k] = 64'h0;

        #1;
        check_zero("reset_state");
        repeat (3) @(negedge clk);
        reset_l = 1'b1;
        tick();
        tick();
        chk("idle_not_busy", 64'({busy, done}), 64'h0);

        // Plain ExpandKey with fixed latency and literal pins.
        run(1'b0, 128'h0, 1'b0, 1'b0, 1'b0, -1, 1'b1);
        chk("first_enc_block_zero", enc_log[0], 64'h0);

        // Salted run with literal salt.
        run(1'b1, 128'h00000001_00000002_00000003_00000004, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        chk("salt_blk0", enc_log[0], 64'h00000001_00000002);
        chk("salt_blk1", enc_log[1], 64'h00000000_A5A5A5A0);
        chk("salt_blk2", enc_log[2], 64'hA5A5A5A0_A5A5A5A7);

        // Random latency, random salt, extra start pulses, spurious enc_done.
        run(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 1'b1, -1, 1'b0);

        // Reset during ENC_WAIT of block 300, then a full recovery run.
        run(1'b0, 128'h0, 1'b0, 1'b0, 1'b0, 300, 1'b0);
        run(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 1'b0, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
